// File: rtl/programm_lader_pkg.sv
// Shared definitions for the program loader: state encoding, error codes, fixed widths.
package programm_lader_pkg;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [2:0] {
        LEERLAUF   = 3'd0,
        LAENGE     = 3'd1,
        DATEN      = 3'd2,
        SCHREIBEN  = 3'd3,
        PRUEFSUMME = 3'd4,
        HALTEN     = 3'd5,
        FERTIG     = 3'd6,
        FEHLER     = 3'd7
    } zustand_e;

    localparam logic [CODE_W-1:0] CODE_KEIN   = 2'b00;
    localparam logic [CODE_W-1:0] CODE_LAENGE = 2'b01;
    localparam logic [CODE_W-1:0] CODE_SUMME  = 2'b10;

    // States in which a stream word may be taken.
    function automatic logic nimmt_an(input zustand_e z);
        return (z == LAENGE) || (z == DATEN) || (z == PRUEFSUMME);
    endfunction

endpackage

// File: rtl/pruefsummen_akku.sv
// Wrapping checksum accumulator: synchronous clear has priority over add.
module pruefsummen_akku #(
    parameter int unsigned WORDSIZE = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                add_i,
    input  logic [WORDSIZE-1:0] wort_i,
    output logic [WORDSIZE-1:0] summe_o
);

    logic [WORDSIZE-1:0] summe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            summe_q <= '0;
        end else if (clear_i) begin
            summe_q <= '0;
        end else if (add_i) begin
            summe_q <= summe_q + wort_i;
        end
    end

    assign summe_o = summe_q;

endmodule

// File: rtl/programm_lader.sv
// Streams a length-prefixed, checksummed program image into instruction RAM while the CPU
// is held in reset, then releases the CPU and hands the RAM address port over to it.
module programm_lader
    import programm_lader_pkg::*;
#(
    parameter int unsigned WORDSIZE     = 32,
    parameter int unsigned WORDS        = 256,
    parameter int unsigned RESET_HALTEN = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [WORDSIZE-1:0] EingangDaten,
    input  logic                EingangGueltig,
    output logic                EingangBereit,
    output logic [ADR_W-1:0]    RAMAdresse,
    output logic [WORDSIZE-1:0] RAMDaten,
    output logic                RAMSchreiben,
    input  logic                RAMGeschrieben,
    input  logic [ADR_W-1:0]    CPUInstruktionAdresse,
    output logic                CPUReset,
    output logic                Fertig,
    output logic                Fehler,
    output logic [CODE_W-1:0]   FehlerCode
);

    localparam int unsigned LEN_W  = $clog2(WORDS + 1);
    localparam int unsigned HALT_W = (RESET_HALTEN > 1) ? $clog2(RESET_HALTEN) : 1;

    zustand_e            zustand_q, zustand_d;
    logic [LEN_W-1:0]    laenge_q, laenge_d;
    logic [LEN_W-1:0]    adr_q, adr_d, adr_naechst;
    logic [WORDSIZE-1:0] daten_q, daten_d;
    logic                schreiben_q, schreiben_d;
    logic [HALT_W-1:0]   halt_q, halt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                bereit_q, bereit_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                fertig_q, fertig_d;
    logic                fehler_q, fehler_d;

    logic                uebernahme;
    logic                summe_clear;
    logic                summe_add;
    logic [WORDSIZE-1:0] summe;

    pruefsummen_akku #(.WORDSIZE(WORDSIZE)) u_akku (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .clear_i (summe_clear),
        .add_i   (summe_add),
        .wort_i  (EingangDaten),
        .summe_o (summe)
    );

    assign uebernahme  = EingangGueltig & bereit_q;
    assign adr_naechst = adr_q + LEN_W'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand_q   <= LEERLAUF;
            laenge_q    <= '0;
            adr_q       <= '0;
            daten_q     <= '0;
            schreiben_q <= 1'b0;
            halt_q      <= '0;
            code_q      <= CODE_KEIN;
            bereit_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            fertig_q    <= 1'b0;
            fehler_q    <= 1'b0;
        end else begin
            zustand_q   <= zustand_d;
            laenge_q    <= laenge_d;
            adr_q       <= adr_d;
            daten_q     <= daten_d;
            schreiben_q <= schreiben_d;
            halt_q      <= halt_d;
            code_q      <= code_d;
            bereit_q    <= bereit_d;
            cpu_reset_q <= cpu_reset_d;
            fertig_q    <= fertig_d;
            fehler_q    <= fehler_d;
        end
    end

    always_comb begin
        zustand_d   = zustand_q;
        laenge_d    = laenge_q;
        adr_d       = adr_q;
        daten_d     = daten_q;
        schreiben_d = schreiben_q;
        halt_d      = halt_q;
        code_d      = code_q;
        summe_clear = 1'b0;
        summe_add   = 1'b0;

        unique case (zustand_q)
            LEERLAUF: begin
                if (Start) begin
                    zustand_d = LAENGE;
                    adr_d     = '0;
                end
            end
            LAENGE: begin
                if (uebernahme) begin
                    if (EingangDaten == '0 || EingangDaten > WORDSIZE'(WORDS)) begin
                        zustand_d = FEHLER;
                        code_d    = CODE_LAENGE;
                    end else begin
                        zustand_d   = DATEN;
                        laenge_d    = LEN_W'(EingangDaten);
                        adr_d       = '0;
                        summe_clear = 1'b1;
                    end
                end
            end
            DATEN: begin
                if (uebernahme) begin
                    zustand_d   = SCHREIBEN;
                    daten_d     = EingangDaten;
                    summe_add   = 1'b1;
                    schreiben_d = 1'b1;
                end
            end
            SCHREIBEN: begin
                // Request, data and address stay frozen until the RAM acknowledges.
                if (RAMGeschrieben) begin
                    schreiben_d = 1'b0;
                    adr_d       = adr_naechst;
                    zustand_d   = (adr_naechst == laenge_q) ? PRUEFSUMME : DATEN;
                end
            end
            PRUEFSUMME: begin
                if (uebernahme) begin
                    if (EingangDaten == summe) begin
                        zustand_d = HALTEN;
                        halt_d    = '0;
                    end else begin
                        zustand_d = FEHLER;
                        code_d    = CODE_SUMME;
                    end
                end
            end
            HALTEN: begin
                if (halt_q == HALT_W'(RESET_HALTEN - 1)) begin
                    zustand_d = FERTIG;
                end else begin
                    halt_d = halt_q + HALT_W'(1);
                end
            end
            FERTIG, FEHLER: begin
                if (Start) begin
                    zustand_d = LAENGE;
                    adr_d     = '0;
                    code_d    = CODE_KEIN;
                end
            end
            default: zustand_d = LEERLAUF;
        endcase

        // Status outputs are registered decodes of the next state.
        bereit_d    = nimmt_an(zustand_d);
        cpu_reset_d = (zustand_d != FERTIG);
        fertig_d    = (zustand_d == FERTIG);
        fehler_d    = (zustand_d == FEHLER);
    end

    assign EingangBereit = bereit_q;
    assign RAMDaten      = daten_q;
    assign RAMSchreiben  = schreiben_q;
    assign CPUReset      = cpu_reset_q;
    assign Fertig        = fertig_q;
    assign Fehler        = fehler_q;
    assign FehlerCode    = code_q;
    // The CPU owns the address port only once it is running.
    assign RAMAdresse    = fertig_q ? CPUInstruktionAdresse : ADR_W'(adr_q);

endmodule

// File: tb/tb_programm_lader.sv
// Directed bench for programm_lader with a simple instruction RAM model using a programmable ack delay.
module tb_programm_lader;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] EingangDaten = '0;
    logic        EingangGueltig = 1'b0;
    logic        EingangBereit;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMDaten;
    logic        RAMSchreiben;
    logic        RAMGeschrieben = 1'b0;
    logic [31:0] CPUInstruktionAdresse = '0;
    logic        CPUReset;
    logic        Fertig;
    logic        Fehler;
    logic [1:0]  FehlerCode;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 0;
    int ack_cnt = 0;
    int write_cnt = 0;
    int schreib_cyc = 0;
    logic [31:0] mem [0:255];

    programm_lader dut (
        .Clock                 (Clock),
        .Reset                 (Reset),
        .Start                 (Start),
        .EingangDaten          (EingangDaten),
        .EingangGueltig        (EingangGueltig),
        .EingangBereit         (EingangBereit),
        .RAMAdresse            (RAMAdresse),
        .RAMDaten              (RAMDaten),
        .RAMSchreiben          (RAMSchreiben),
        .RAMGeschrieben        (RAMGeschrieben),
        .CPUInstruktionAdresse (CPUInstruktionAdresse),
        .CPUReset              (CPUReset),
        .Fertig                (Fertig),
        .Fehler                (Fehler),
        .FehlerCode            (FehlerCode)
    );

    always #5 Clock = ~Clock;

    // RAM model: acknowledges a pending write after ack_delay falling edges, one cycle pulse.
    always @(negedge Clock) begin
        if (Reset) begin
            RAMGeschrieben = 1'b0;
            ack_cnt = 0;
        end else if (RAMGeschrieben) begin
            RAMGeschrieben = 1'b0;
        end else if (RAMSchreiben) begin
            schreib_cyc++;
            if (ack_cnt == ack_delay) begin
                RAMGeschrieben = 1'b1;
                mem[RAMAdresse[7:0]] = RAMDaten;
                write_cnt++;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    task automatic do_start();
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_transfer(input logic [31:0] w, input bit keep);
        bit got = 1'b0;
        EingangDaten   = w;
        EingangGueltig = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clock);
            if (EingangBereit) begin
                @(posedge Clock);
                #1;
                got = 1'b1;
            end
        end
        if (!keep) EingangGueltig = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL transfer: word %0h not accepted, bereit=%b expected 1", w, EingangBereit);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        n_vec++;
        if ({EingangBereit, RAMSchreiben, CPUReset, Fertig, Fehler, FehlerCode} !== 7'b0010000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0010000",
                     {EingangBereit, RAMSchreiben, CPUReset, Fertig, Fehler, FehlerCode});
        end
        n_vec++;
        if ({RAMAdresse, RAMDaten} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_buses: got adr=%0h daten=%0h expected 0/0", RAMAdresse, RAMDaten);
        end
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        n_vec++;
        if ({EingangBereit, CPUReset} !== 2'b01) begin
            n_err++;
            $display("FAIL idle: got bereit/cpureset=%b expected 01", {EingangBereit, CPUReset});
        end
    endtask

    task automatic test_good_image();
        ack_delay = 0;
        write_cnt = 0;
        do_start();
        n_vec++;
        if (EingangBereit !== 1'b1) begin
            n_err++;
            $display("FAIL start_bereit: got %b expected 1", EingangBereit);
        end
        wait_transfer(32'd3, 1'b0);
        wait_transfer(32'd5, 1'b0);
        wait_transfer(32'd7, 1'b0);
        wait_transfer(32'd9, 1'b0);
        wait_transfer(32'd21, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({CPUReset, Fertig} !== 2'b10) begin
                n_err++;
                $display("FAIL halten_%0d: got cpureset/fertig=%b expected 10", k, {CPUReset, Fertig});
            end
            @(posedge Clock);
            #1;
        end
        n_vec++;
        if ({CPUReset, Fertig, Fehler, FehlerCode} !== 5'b01000) begin
            n_err++;
            $display("FAIL release: got %b expected 01000", {CPUReset, Fertig, Fehler, FehlerCode});
        end
        n_vec++;
        if ({mem[0], mem[1], mem[2]} !== {32'd5, 32'd7, 32'd9} || write_cnt != 3) begin
            n_err++;
            $display("FAIL good_ram: got %0d,%0d,%0d writes=%0d expected 5,7,9 writes=3",
                     mem[0], mem[1], mem[2], write_cnt);
        end
    endtask

    task automatic test_checksum_error();
        write_cnt = 0;
        do_start();
        n_vec++;
        if ({CPUReset, Fertig, EingangBereit} !== 3'b101) begin
            n_err++;
            $display("FAIL restart: got cpureset/fertig/bereit=%b expected 101", {CPUReset, Fertig, EingangBereit});
        end
        wait_transfer(32'd2, 1'b0);
        wait_transfer(32'd1, 1'b0);
        wait_transfer(32'd2, 1'b0);
        wait_transfer(32'd4, 1'b0);
        n_vec++;
        if ({Fehler, FehlerCode, CPUReset, RAMSchreiben, Fertig} !== 6'b110100) begin
            n_err++;
            $display("FAIL sum_err: got %b expected 110100", {Fehler, FehlerCode, CPUReset, RAMSchreiben, Fertig});
        end
        repeat (5) @(posedge Clock);
        #1;
        n_vec++;
        if (write_cnt != 2 || RAMSchreiben !== 1'b0 || Fehler !== 1'b1) begin
            n_err++;
            $display("FAIL sum_err_hold: got writes=%0d schreiben=%b fehler=%b expected 2/0/1",
                     write_cnt, RAMSchreiben, Fehler);
        end
    endtask

    task automatic test_bad_length();
        write_cnt   = 0;
        schreib_cyc = 0;
        do_start();
        n_vec++;
        if ({Fehler, FehlerCode} !== 3'b000) begin
            n_err++;
            $display("FAIL err_clear: got fehler/code=%b expected 000", {Fehler, FehlerCode});
        end
        wait_transfer(32'd0, 1'b0);
        n_vec++;
        if ({Fehler, FehlerCode} !== 3'b101) begin
            n_err++;
            $display("FAIL len_zero: got fehler/code=%b expected 101", {Fehler, FehlerCode});
        end
        do_start();
        wait_transfer(32'd257, 1'b0);
        n_vec++;
        if ({Fehler, FehlerCode, CPUReset} !== 4'b1011) begin
            n_err++;
            $display("FAIL len_257: got fehler/code/cpureset=%b expected 1011", {Fehler, FehlerCode, CPUReset});
        end
        repeat (3) @(posedge Clock);
        #1;
        n_vec++;
        if (write_cnt != 0 || schreib_cyc != 0) begin
            n_err++;
            $display("FAIL len_nowrite: got writes=%0d schreib_cycles=%0d expected 0/0", write_cnt, schreib_cyc);
        end
    endtask

    task automatic test_max_length();
        logic [31:0] sum = '0;
        bit          ok  = 1'b1;
        write_cnt = 0;
        do_start();
        wait_transfer(32'd256, 1'b0);
        for (int i = 0; i < 256; i++) begin
            wait_transfer(32'(i * 3 + 1), 1'b0);
            sum = sum + 32'(i * 3 + 1);
        end
        wait_transfer(sum, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        n_vec++;
        if ({Fertig, Fehler, CPUReset} !== 3'b100 || write_cnt != 256) begin
            n_err++;
            $display("FAIL max_len: got fertig/fehler/cpureset=%b writes=%0d expected 100 writes=256",
                     {Fertig, Fehler, CPUReset}, write_cnt);
        end
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== 32'(i * 3 + 1)) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL max_len_ram: got mem[255]=%0d expected %0d (or earlier word wrong)", mem[255], 255 * 3 + 1);
        end
    endtask

    task automatic test_ack_delay();
        logic [31:0] w [0:2];
        int held;
        w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'h15;
        ack_delay = 5;
        write_cnt = 0;
        do_start();
        wait_transfer(32'd2, 1'b0);
        wait_transfer(w[0], 1'b1);
        for (int i = 0; i < 2; i++) begin
            EingangDaten = w[i + 1];
            held = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge Clock);
                #1;
                if (!RAMSchreiben) break;
                held++;
                n_vec++;
                if ({EingangBereit, RAMAdresse, RAMDaten} !== {1'b0, 32'(i), w[i]}) begin
                    n_err++;
                    $display("FAIL ack_stable_%0d: got bereit=%b adr=%0h daten=%0h expected 0/%0h/%0h",
                             i, EingangBereit, RAMAdresse, RAMDaten, i, w[i]);
                end
            end
            n_vec++;
            if (held != 6 || EingangBereit !== 1'b1) begin
                n_err++;
                $display("FAIL ack_wait_%0d: got held=%0d bereit=%b expected 6/1", i, held, EingangBereit);
            end
            @(posedge Clock);
            #1;
        end
        EingangGueltig = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        n_vec++;
        if (Fertig !== 1'b1 || write_cnt != 2 || mem[0] !== w[0] || mem[1] !== w[1]) begin
            n_err++;
            $display("FAIL ack_result: got fertig=%b writes=%0d mem=%0h,%0h expected 1/2/a,b",
                     Fertig, write_cnt, mem[0], mem[1]);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_midload();
        ack_delay = 1;
        do_start();
        wait_transfer(32'd4, 1'b0);
        wait_transfer(32'd3, 1'b0);
        wait_transfer(32'd4, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        n_vec++;
        if ({EingangBereit, RAMSchreiben, CPUReset, Fertig, Fehler, FehlerCode} !== 7'b0010000
            || {RAMAdresse, RAMDaten} !== 64'h0) begin
            n_err++;
            $display("FAIL midload_reset: got flags=%b adr=%0h daten=%0h expected 0010000/0/0",
                     {EingangBereit, RAMSchreiben, CPUReset, Fertig, Fehler, FehlerCode}, RAMAdresse, RAMDaten);
        end
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        write_cnt = 0;
        do_start();
        wait_transfer(32'd4, 1'b0);
        wait_transfer(32'd3, 1'b0);
        wait_transfer(32'd4, 1'b0);
        wait_transfer(32'd5, 1'b0);
        wait_transfer(32'd6, 1'b0);
        wait_transfer(32'd18, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        n_vec++;
        if (Fertig !== 1'b1 || write_cnt != 4 ||
            {mem[0], mem[1], mem[2], mem[3]} !== {32'd3, 32'd4, 32'd5, 32'd6}) begin
            n_err++;
            $display("FAIL midload_reload: got fertig=%b writes=%0d mem=%0d,%0d,%0d,%0d expected 1/4/3,4,5,6",
                     Fertig, write_cnt, mem[0], mem[1], mem[2], mem[3]);
        end
        ack_delay = 0;
    endtask

    task automatic test_cpu_address();
        CPUInstruktionAdresse = 32'd7;
        #1;
        n_vec++;
        if (RAMAdresse !== 32'd7) begin
            n_err++;
            $display("FAIL cpu_adr: got %0h expected 7", RAMAdresse);
        end
        CPUInstruktionAdresse = 32'h0000_1234;
        #1;
        n_vec++;
        if (RAMAdresse !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL cpu_adr2: got %0h expected 1234", RAMAdresse);
        end
        do_start();
        n_vec++;
        if ({CPUReset, Fertig} !== 2'b10 || RAMAdresse !== 32'd0) begin
            n_err++;
            $display("FAIL cpu_restart: got cpureset/fertig=%b adr=%0h expected 10/0", {CPUReset, Fertig}, RAMAdresse);
        end
        // A second Start while loading must not disturb the load.
        do_start();
        n_vec++;
        if ({EingangBereit, Fehler, CPUReset} !== 3'b101) begin
            n_err++;
            $display("FAIL start_ignored: got bereit/fehler/cpureset=%b expected 101", {EingangBereit, Fehler, CPUReset});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_image();
        test_checksum_error();
        test_bad_length();
        test_max_length();
        test_ack_delay();
        test_reset_midload();
        test_cpu_address();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
